// File: rtl/noc_credit_link_buffer.sv
// rtl/noc_credit_link_buffer.sv - credit-tracked elastic link stage between neighbouring NoC routers
module noc_credit_link_buffer #(
  parameter int FLIT_WIDTH         = 32,
  parameter int DEST_WIDTH         = 6,
  parameter int BUFFER_DEPTH       = 4,
  parameter int DOWNSTREAM_CREDITS = 4,
  localparam int CNT_W = $clog2(((BUFFER_DEPTH > DOWNSTREAM_CREDITS) ?
                                 BUFFER_DEPTH : DOWNSTREAM_CREDITS) + 1)
) (
  input  logic                  clk_noc,
  input  logic                  rst_n,
  input  logic [FLIT_WIDTH-1:0] data_in,
  input  logic [DEST_WIDTH-1:0] dest_in,
  input  logic                  is_tail_in,
  input  logic                  send_in,
  output logic                  credit_out,
  output logic [FLIT_WIDTH-1:0] data_out,
  output logic [DEST_WIDTH-1:0] dest_out,
  output logic                  is_tail_out,
  output logic                  send_out,
  input  logic                  credit_in,
  output logic [CNT_W-1:0]      occupancy,
  output logic [CNT_W-1:0]      credit_count,
  output logic                  overflow_err,
  output logic                  credit_err
);

  localparam int PTR_W   = $clog2(BUFFER_DEPTH);
  localparam int ENTRY_W = FLIT_WIDTH + DEST_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(BUFFER_DEPTH);
  localparam logic [CNT_W-1:0] MAXCRED_C = CNT_W'(DOWNSTREAM_CREDITS);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  // Flit storage; an entry is {is_tail, dest, data}
  logic [ENTRY_W-1:0] mem_q [BUFFER_DEPTH];
  logic [ENTRY_W-1:0] mem_d [BUFFER_DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      occ_q, occ_d;
  logic [CNT_W-1:0]      cred_q, cred_d;
  logic [FLIT_WIDTH-1:0] data_q, data_d;
  logic [DEST_WIDTH-1:0] dest_q, dest_d;
  logic                  tail_q, tail_d;
  logic                  send_q, send_d;
  logic                  credit_q, credit_d;
  logic                  ovf_q, ovf_d;
  logic                  cerr_q, cerr_d;

  logic                  full;
  logic                  pop;
  logic                  wr_en;
  logic                  ovf_evt;
  logic                  credit_sat;
  logic [ENTRY_W-1:0]    head;
  logic [ENTRY_W-1:0]    wr_entry;

  // Handshake decisions for this edge; pop only looks at registered state so a
  // flit written into an empty buffer waits one cycle before it can leave.
  always_comb begin
    full       = (occ_q == DEPTH_C);
    pop        = (occ_q != '0) && (cred_q != '0);
    wr_en      = send_in && (!full || pop);
    ovf_evt    = send_in && full && !pop;
    credit_sat = credit_in && (cred_q == MAXCRED_C) && !pop;
    head       = mem_q[rd_ptr_q];
    wr_entry   = {is_tail_in, dest_in, data_in};
  end

  // Storage write and pointer advance; when full and popping, wr_ptr equals
  // rd_ptr and the old head is read out before being overwritten.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = wr_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  // Occupancy and downstream credit bookkeeping
  always_comb begin
    occ_d  = occ_q;
    cred_d = cred_q;
    case ({wr_en, pop})
      2'b10:   occ_d = occ_q + ONE_C;
      2'b01:   occ_d = occ_q - ONE_C;
      default: occ_d = occ_q;
    endcase
    // A surplus credit at the ceiling is dropped rather than wrapping the count.
    case ({credit_in && !credit_sat, pop})
      2'b10:   cred_d = cred_q + ONE_C;
      2'b01:   cred_d = cred_q - ONE_C;
      default: cred_d = cred_q;
    endcase
  end

  // Registered output stage: a pop launches the head flit and returns one credit upstream
  always_comb begin
    data_d   = data_q;
    dest_d   = dest_q;
    tail_d   = tail_q;
    send_d   = 1'b0;
    credit_d = 1'b0;
    if (pop) begin
      data_d   = head[FLIT_WIDTH-1:0];
      dest_d   = head[FLIT_WIDTH +: DEST_WIDTH];
      tail_d   = head[ENTRY_W-1];
      send_d   = 1'b1;
      credit_d = 1'b1;
    end
  end

  // Sticky protocol-violation flags
  always_comb begin
    ovf_d  = ovf_q  | ovf_evt;
    cerr_d = cerr_q | credit_sat;
  end

  // Control state register; reset drops buffered flits without returning credits
  always_ff @(posedge clk_noc) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      cred_q   <= MAXCRED_C;
      data_q   <= '0;
      dest_q   <= '0;
      tail_q   <= 1'b0;
      send_q   <= 1'b0;
      credit_q <= 1'b0;
      ovf_q    <= 1'b0;
      cerr_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      cred_q   <= cred_d;
      data_q   <= data_d;
      dest_q   <= dest_d;
      tail_q   <= tail_d;
      send_q   <= send_d;
      credit_q <= credit_d;
      ovf_q    <= ovf_d;
      cerr_q   <= cerr_d;
    end
  end

  // Storage array register; contents are don't-care while occupancy says empty
  always_ff @(posedge clk_noc) begin
    mem_q <= mem_d;
  end

  assign data_out     = data_q;
  assign dest_out     = dest_q;
  assign is_tail_out  = tail_q;
  assign send_out     = send_q;
  assign credit_out   = credit_q;
  assign occupancy    = occ_q;
  assign credit_count = cred_q;
  assign overflow_err = ovf_q;
  assign credit_err   = cerr_q;

endmodule

// File: tb/tb_noc_credit_link_buffer.sv
// tb/tb_noc_credit_link_buffer.sv - scoreboard bench for noc_credit_link_buffer
module tb_noc_credit_link_buffer;

  localparam int DEPTH = 4;
  localparam int DC    = 4;

  typedef struct packed {
    logic [31:0] d;
    logic [5:0]  de;
    logic        t;
  } flit_t;

  logic        clk_noc = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data_in = '0;
  logic [5:0]  dest_in = '0;
  logic        is_tail_in = 1'b0;
  logic        send_in = 1'b0;
  logic        credit_in = 1'b0;
  logic        credit_out;
  logic [31:0] data_out;
  logic [5:0]  dest_out;
  logic        is_tail_out;
  logic        send_out;
  logic [2:0]  occupancy;
  logic [2:0]  credit_count;
  logic        overflow_err;
  logic        credit_err;

  noc_credit_link_buffer dut (
    .clk_noc(clk_noc), .rst_n(rst_n), .data_in(data_in), .dest_in(dest_in),
    .is_tail_in(is_tail_in), .send_in(send_in), .credit_out(credit_out),
    .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out),
    .send_out(send_out), .credit_in(credit_in), .occupancy(occupancy),
    .credit_count(credit_count), .overflow_err(overflow_err), .credit_err(credit_err)
  );

  always #5 clk_noc = ~clk_noc;

  // reference model state (buffer contents as a queue, credits as an integer)
  flit_t mq[$];
  flit_t exp_q[$];
  int    m_cred = DC;
  bit    m_send = 0;
  bit    m_ovf = 0;
  bit    m_cerr = 0;
  int    up_cred = DEPTH;
  int    ds_held = 0;
  int    n_pops = 0;
  int    n_acc = 0;

  int    n_checks = 0;
  int    n_pass = 0;
  int    n_sent = 0;
  int    n_cred = 0;
  bit    mon_en = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask

  // one clock edge of the reference rules, applied with the inputs that edge saw
  task automatic model_edge(input bit rst, input bit snd, input flit_t f, input bit cin);
    bit    p;
    flit_t h;
    if (rst) begin
      mq.delete();
      exp_q.delete();
      m_send = 0; m_cred = DC; m_ovf = 0; m_cerr = 0;
      up_cred = DEPTH; ds_held = 0;
      return;
    end
    p = (mq.size() > 0) && (m_cred > 0);
    if (p) begin
      h = mq.pop_front();
      exp_q.push_back(h);
      up_cred++;
      ds_held++;
      n_pops++;
    end
    m_send = p;
    if (snd) begin
      if (mq.size() < DEPTH) begin
        mq.push_back(f);
        n_acc++;
      end else begin
        m_ovf = 1;
      end
    end
    if (cin && m_cred == DC && !p) m_cerr = 1;
    else m_cred = m_cred + (cin ? 1 : 0) - (p ? 1 : 0);
  endtask

  task automatic step(input bit rst, input bit snd, input flit_t f, input bit cin);
    rst_n      = !rst;
    send_in    = snd;
    data_in    = f.d;
    dest_in    = f.de;
    is_tail_in = f.t;
    credit_in  = cin;
    @(posedge clk_noc);
    #1;
    model_edge(rst, snd, f, cin);
    rst_n     = 1'b1;
    send_in   = 1'b0;
    credit_in = 1'b0;
  endtask

  function automatic flit_t mk(input logic [31:0] d, input logic [5:0] de, input logic t);
    flit_t f;
    f.d = d; f.de = de; f.t = t;
    return f;
  endfunction

  // monitor: compares registered outputs with the model and pops the scoreboard on every send
  always @(negedge clk_noc) begin
    if (mon_en) begin
      flit_t e;
      check("send_out", 64'(send_out), 64'(m_send));
      check("credit_out", 64'(credit_out), 64'(m_send));
      check("occupancy", 64'(occupancy), 64'(mq.size()));
      check("credit_count", 64'(credit_count), 64'(m_cred));
      check("overflow_err", 64'(overflow_err), 64'(m_ovf));
      check("credit_err", 64'(credit_err), 64'(m_cerr));
      if (credit_out) n_cred++;
      if (send_out) begin
        n_sent++;
        if (exp_q.size() == 0) begin
          check("unexpected_send", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("data_out", 64'(data_out), 64'(e.d));
          check("dest_out", 64'(dest_out), 64'(e.de));
          check("is_tail_out", 64'(is_tail_out), 64'(e.t));
        end
      end
    end
  end

  initial begin
    flit_t z;
    int    base, pops0, acc0, cred0;
    bit    snd, cin;
    z = mk('0, '0, 1'b0);

    // T1: reset held 3 cycles with send_in asserted
    for (int i = 0; i < 3; i++) begin
      step(1, 1, mk(32'hFFFF_FFFF, 6'h3F, 1'b1), 0);
      mon_en = 1;
    end
    check("t1_send_out", 64'(send_out), 64'(0));
    check("t1_credit_out", 64'(credit_out), 64'(0));
    check("t1_data_out", 64'(data_out), 64'(0));
    check("t1_dest_out", 64'(dest_out), 64'(0));
    check("t1_is_tail_out", 64'(is_tail_out), 64'(0));
    check("t1_occupancy", 64'(occupancy), 64'(0));
    check("t1_credit_count", 64'(credit_count), 64'(4));
    check("t1_errs", 64'({overflow_err, credit_err}), 64'(0));

    // T2: minimum latency of a single flit
    step(0, 1, mk(32'hA5A5_0001, 6'h05, 1'b1), 0);
    check("t2_no_bypass", 64'(send_out), 64'(0));
    step(0, 0, z, 0);
    check("t2_send_out", 64'(send_out), 64'(1));
    check("t2_credit_out", 64'(credit_out), 64'(1));
    check("t2_data_out", 64'(data_out), 64'h0000_0000_A5A5_0001);
    check("t2_dest_out", 64'(dest_out), 64'(6'h05));
    check("t2_is_tail_out", 64'(is_tail_out), 64'(1));
    check("t2_credit_count", 64'(credit_count), 64'(3));
    step(0, 0, z, 0);
    check("t2_pulse_ends", 64'(send_out), 64'(0));
    check("t2_data_held", 64'(data_out), 64'h0000_0000_A5A5_0001);

    // T3: credit stall with 8 back-to-back flits
    step(1, 0, z, 0);
    base = n_sent;
    for (int i = 0; i < 8; i++) step(0, 1, mk(32'h3000_0000 + 32'(i), 6'(i), 1'(i % 2)), 0);
    step(0, 0, z, 0);
    check("t3_sent_4", 64'(n_sent - base), 64'(4));
    check("t3_occupancy", 64'(occupancy), 64'(4));
    check("t3_credit_count", 64'(credit_count), 64'(0));
    step(0, 0, z, 1);
    step(0, 0, z, 0);
    step(0, 0, z, 0);
    check("t3_one_more", 64'(n_sent - base), 64'(5));

    // T4: full buffer, write and pop on the same edge
    step(0, 1, mk(32'h3000_0008, 6'h08, 1'b1), 0);
    check("t4_full", 64'(occupancy), 64'(4));
    step(0, 0, z, 1);
    step(0, 1, mk(32'h3000_0009, 6'h09, 1'b0), 1);
    check("t4_occupancy", 64'(occupancy), 64'(4));
    check("t4_no_overflow", 64'(overflow_err), 64'(0));

    // T5: overflow drop, then surplus credit
    step(1, 0, z, 0);
    for (int i = 0; i < 8; i++) step(0, 1, mk(32'h5000_0000 + 32'(i), 6'(i), 1'b0), 0);
    step(0, 1, mk(32'hDEAD_BEEF, 6'h2A, 1'b1), 0);
    check("t5_overflow_err", 64'(overflow_err), 64'(1));
    check("t5_occupancy", 64'(occupancy), 64'(4));
    for (int i = 0; i < 4; i++) begin
      step(0, 0, z, 1);
      step(0, 0, z, 0);
    end
    step(0, 0, z, 0);
    check("t5_drained", 64'(occupancy), 64'(0));
    check("t5_marker_absent", 64'(exp_q.size()), 64'(0));
    for (int i = 0; i < 4; i++) step(0, 0, z, 1);
    check("t5_credits_full", 64'(credit_count), 64'(4));
    check("t5_no_cerr_yet", 64'(credit_err), 64'(0));
    step(0, 0, z, 1);
    check("t5_credit_err", 64'(credit_err), 64'(1));
    check("t5_count_sat", 64'(credit_count), 64'(4));
    check("t5_ovf_sticky", 64'(overflow_err), 64'(1));

    // T6: random traffic obeying the credit protocol on both sides
    step(1, 0, z, 0);
    base  = n_sent;
    cred0 = n_cred;
    pops0 = n_pops;
    acc0  = n_acc;
    for (int i = 0; i < 10000; i++) begin
      snd = (up_cred > 0) && ($urandom_range(0, 3) != 0);
      cin = (ds_held > 0) && ($urandom_range(0, 2) != 0);
      if (snd) up_cred--;
      if (cin) ds_held--;
      step(0, snd, mk($urandom, 6'($urandom), 1'($urandom)), cin);
    end
    for (int i = 0; i < 60 && (mq.size() > 0 || ds_held > 0); i++) begin
      cin = (ds_held > 0);
      if (cin) ds_held--;
      step(0, 0, z, cin);
    end
    step(0, 0, z, 0);
    check("t6_drain_bound", 64'(mq.size()), 64'(0));
    check("t6_all_delivered", 64'(n_sent - base), 64'(n_acc - acc0));
    check("t6_sends", 64'(n_sent - base), 64'(n_pops - pops0));
    check("t6_credits", 64'(n_cred - cred0), 64'(n_pops - pops0));
    check("t6_errs", 64'({overflow_err, credit_err}), 64'(0));
    check("t6_credit_count", 64'(credit_count), 64'(4));

    mon_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
